mre_accumulator: RTL and testbench

Error-metric collector that sits at the output end of the approximate FIR datapath. Each handshake accepts one pair: the approximate filter output and the exact reference output for the same sample. The block computes the relative error |approx − exact| / |exact| as an unsigned fixed-point ratio using a bit-serial restoring divider, and accumulates it over a run of NSAMP samples. At the end of the run it presents the ratio sum, the sample count and the zero-denominator count, so software can form the mean relative error (MRE).

---
 rtl/mre_accumulator.sv | 127 ++++++++++++
 tb/tb_mre_accumulator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mre_accumulator.sv
// Relative-error accumulator for the approximate FIR datapath: per pair it divides
// |approx - exact| by |exact| with a bit-serial restoring divider and sums the ratios over a run.
module mre_accumulator #(
  parameter int W     = 16,
  parameter int FRAC  = 16,
  parameter int NSAMP = 1024,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     y_approx,
  input  logic [W-1:0]     y_exact,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_sum,
  output logic             acc_sat,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      zero_cnt
);

  localparam int Q  = W + 1 + FRAC;
  localparam int CW = $clog2(Q + 1);
  localparam logic [15:0] NSAMP_L = 16'(NSAMP);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DIV, S_ACC, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [W:0]     diff, num, trial, rem_sub;
  logic [W-1:0]   den, den_reg, rem_reg, rem_next;
  logic [Q-1:0]   dvd_reg, quo_reg;
  logic [CW-1:0]  iter_reg;
  logic           zero_reg, fits, div_last, run_end;
  logic [ACC_W:0] sum_ext;
  logic [15:0]    cnt_inc;

  always_comb begin
    diff     = {y_approx[W-1], y_approx} - {y_exact[W-1], y_exact};
    num      = diff[W] ? -diff : diff;
    // -32768 negates to 0x8000, which read unsigned is the required 32768
    den      = y_exact[W-1] ? -y_exact : y_exact;
    trial    = {rem_reg, dvd_reg[Q-1]};
    rem_sub  = trial - {1'b0, den_reg};
    fits     = trial >= {1'b0, den_reg};
    rem_next = fits ? rem_sub[W-1:0] : trial[W-1:0];
    div_last = iter_reg == CW'(Q - 1);
    sum_ext  = {1'b0, acc_sum} + (ACC_W + 1)'(quo_reg);
    cnt_inc  = sample_cnt + 16'd1;
    run_end  = cnt_inc == NSAMP_L;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_WAIT;
      S_WAIT:         if (in_valid) state_next = (den == '0) ? S_ACC : S_DIV;
      S_DIV:          if (div_last) state_next = S_ACC;
      S_ACC:          state_next = run_end ? S_DONE : S_WAIT;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg  <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      acc_sum    <= '0;
      acc_sat    <= 1'b0;
      sample_cnt <= '0;
      zero_cnt   <= '0;
      den_reg    <= '0;
      rem_reg    <= '0;
      dvd_reg    <= '0;
      quo_reg    <= '0;
      iter_reg   <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      in_ready  <= state_next == S_WAIT;
      busy      <= state_next inside {S_WAIT, S_DIV, S_ACC};
      done      <= state_next == S_DONE;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_sum    <= '0;
            acc_sat    <= 1'b0;
            sample_cnt <= '0;
            zero_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            den_reg  <= den;
            dvd_reg  <= {num, {FRAC{1'b0}}};
            rem_reg  <= '0;
            quo_reg  <= '0;
            iter_reg <= '0;
            zero_reg <= den == '0;
          end
        end
        S_DIV: begin
          rem_reg  <= rem_next;
          dvd_reg  <= {dvd_reg[Q-2:0], 1'b0};
          quo_reg  <= {quo_reg[Q-2:0], fits};
          iter_reg <= iter_reg + CW'(1);
        end
        S_ACC: begin
          // a zero-denominator pair leaves quo_reg at 0, so the add is harmless
          if (acc_sat || sum_ext[ACC_W]) begin
            acc_sum <= '1;
            acc_sat <= 1'b1;
          end else begin
            acc_sum <= sum_ext[ACC_W-1:0];
          end
          sample_cnt <= cnt_inc;
          zero_cnt   <= zero_cnt + 16'(zero_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mre_accumulator.sv
// Bench for mre_accumulator: several instances with different run lengths and accumulator
// widths, table vectors, hand-written timing sequences and a random run against a ratio model.
module tb_mre_accumulator;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rstN;
  logic [NI-1:0] start_v, valid_v, ready_v, busy_v, done_v, sat_v;
  logic [15:0] ya [NI];
  logic [15:0] ye [NI];
  logic [47:0] sum_v [NI];
  logic [15:0] scnt_v [NI];
  logic [15:0] zcnt_v [NI];

  always #5 clk = ~clk;

  // 0: NSAMP=1, 1: NSAMP=3, 2: NSAMP=4, 3: NSAMP=9 with ACC_W=34, 4: NSAMP=12 random
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int AW  = (gi == 3) ? 34 : 48;
      localparam int NSV = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : (gi == 3) ? 9 : 12;
      logic [AW-1:0] s;
      mre_accumulator #(.W(16), .FRAC(16), .NSAMP(NSV), .ACC_W(AW)) dut (
        .clk(clk), .rstN(rstN), .start(start_v[gi]), .in_valid(valid_v[gi]),
        .in_ready(ready_v[gi]), .y_approx(ya[gi]), .y_exact(ye[gi]), .busy(busy_v[gi]),
        .done(done_v[gi]), .acc_sum(s), .acc_sat(sat_v[gi]), .sample_cnt(scnt_v[gi]),
        .zero_cnt(zcnt_v[gi])
      );
      assign sum_v[gi] = 48'(s);
    end
  endgenerate

  typedef struct {
    logic [15:0]     a;
    logic [15:0]     e;
    longint unsigned q;
    logic            z;
  } vec_t;

  vec_t vt [10];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint unsigned got, longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // Returns at the negedge right after the handshake edge
  task automatic send(int k, logic [15:0] a, logic [15:0] e);
    int n;
    n = 0;
    ya[k] = a;
    ye[k] = e;
    valid_v[k] = 1'b1;
    while (!ready_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", 64'(ready_v[k]), 1);
    @(negedge clk);
    valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(int k);
    int n;
    n = 0;
    while (!done_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 64'(done_v[k]), 1);
  endtask

  task automatic wait_ready_or_done(int k);
    int n;
    n = 0;
    while (!ready_v[k] && !done_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(ready_v[k] | done_v[k]), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, pulses;
    longint msum, q;
    int mz, da, de, d, num, den, r;
    logic [15:0] ra, re;

    vt[0] = '{16'd110,      16'd100,      64'd6553,    1'b0};
    vt[1] = '{16'd32767,    16'h8000,     64'd131070,  1'b0};
    vt[2] = '{16'd5,        16'd0,        64'd0,       1'b1};
    vt[3] = '{-16'sd50,     -16'sd100,    64'd32768,   1'b0};
    vt[4] = '{16'd1234,     16'd1234,     64'd0,       1'b0};
    vt[5] = '{16'h8000,     16'd32767,    64'd131074,  1'b0};
    vt[6] = '{16'd0,        16'd1,        64'd65536,   1'b0};
    vt[7] = '{-16'sd1,      -16'sd3,      64'd43690,   1'b0};
    vt[8] = '{16'd100,      -16'sd7,      64'd1001764, 1'b0};
    vt[9] = '{16'd0,        16'd0,        64'd0,       1'b1};

    start_v = '0;
    valid_v = '0;
    for (int i = 0; i < NI; i++) begin
      ya[i] = '0;
      ye[i] = '0;
    end
    rstN = 1'b0;
    tick(3);
    rstN = 1'b1;
    tick(1);

    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", 64'(ready_v[i]), 0);
      chk("rst_busy", 64'(busy_v[i]), 0);
      chk("rst_done", 64'(done_v[i]), 0);
      chk("rst_sat", 64'(sat_v[i]), 0);
      chk("rst_sum", 64'(sum_v[i]), 0);
      chk("rst_scnt", 64'(scnt_v[i]), 0);
      chk("rst_zcnt", 64'(zcnt_v[i]), 0);
    end

    // in_valid in IDLE is ignored
    ya[0] = 16'd5;
    ye[0] = 16'd3;
    valid_v[0] = 1'b1;
    tick(3);
    chk("idle_ready", 64'(ready_v[0]), 0);
    chk("idle_scnt", 64'(scnt_v[0]), 0);
    valid_v[0] = 1'b0;

    // exact latency of one nonzero-denominator sample
    do_start(0);
    chk("start_ready", 64'(ready_v[0]), 1);
    chk("start_busy", 64'(busy_v[0]), 1);
    send(0, 16'd110, 16'd100);
    chk("div_ready", 64'(ready_v[0]), 0);
    chk("div_busy", 64'(busy_v[0]), 1);
    tick(33);
    chk("early_done", 64'(done_v[0]), 0);
    chk("early_sum", 64'(sum_v[0]), 0);
    tick(1);
    chk("lat_done", 64'(done_v[0]), 1);
    chk("lat_busy", 64'(busy_v[0]), 0);
    chk("lat_ready", 64'(ready_v[0]), 0);
    chk("lat_sum", 64'(sum_v[0]), 6553);
    chk("lat_scnt", 64'(scnt_v[0]), 1);
    chk("lat_zcnt", 64'(zcnt_v[0]), 0);

    for (int i = 0; i < 10; i++) begin
      do_start(0);
      chk("vec_clear_sum", 64'(sum_v[0]), 0);
      send(0, vt[i].a, vt[i].e);
      wait_done(0);
      chk("vec_sum", 64'(sum_v[0]), vt[i].q);
      chk("vec_scnt", 64'(scnt_v[0]), 1);
      chk("vec_zcnt", 64'(zcnt_v[0]), 64'(vt[i].z));
      $display("vec %0d a=%0d e=%0d sum=%0d", i, $signed(vt[i].a), $signed(vt[i].e), sum_v[0]);
    end

    // start and in_valid together in DONE: start wins
    ya[0] = 16'd7;
    ye[0] = 16'd3;
    start_v[0] = 1'b1;
    valid_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    valid_v[0] = 1'b0;
    chk("startwin_ready", 64'(ready_v[0]), 1);
    chk("startwin_scnt", 64'(scnt_v[0]), 0);
    chk("startwin_done", 64'(done_v[0]), 0);

    // zero-denominator pairs
    do_start(1);
    send(1, 16'd5, 16'd0);
    chk("zd_ready_k0", 64'(ready_v[1]), 0);
    tick(1);
    chk("zd_ready_k1", 64'(ready_v[1]), 1);
    chk("zd_zcnt1", 64'(zcnt_v[1]), 1);
    chk("zd_scnt1", 64'(scnt_v[1]), 1);
    send(1, 16'd0, 16'd0);
    tick(1);
    chk("zd_ready2", 64'(ready_v[1]), 1);
    send(1, -16'sd50, -16'sd100);
    wait_done(1);
    chk("zd_sum", 64'(sum_v[1]), 32768);
    chk("zd_scnt", 64'(scnt_v[1]), 3);
    chk("zd_zcnt", 64'(zcnt_v[1]), 2);

    // in_valid held high: one acceptance every 35 cycles
    do_start(2);
    ya[2] = 16'd1234;
    ye[2] = 16'd1234;
    valid_v[2] = 1'b1;
    prev = -1;
    pulses = 0;
    for (int c = 0; c < 200 && !done_v[2]; c++) begin
      if (ready_v[2]) begin
        if (prev >= 0) chk("ready_gap", 64'(c - prev), 35);
        prev = c;
        pulses++;
      end
      @(negedge clk);
    end
    chk("held_pulses", 64'(pulses), 4);
    chk("held_done", 64'(done_v[2]), 1);
    chk("held_sum", 64'(sum_v[2]), 0);
    chk("held_scnt", 64'(scnt_v[2]), 4);
    tick(10);
    chk("done_ready", 64'(ready_v[2]), 0);
    chk("done_scnt", 64'(scnt_v[2]), 4);
    valid_v[2] = 1'b0;
    do_start(2);
    chk("restart_scnt", 64'(scnt_v[2]), 0);
    chk("restart_done", 64'(done_v[2]), 0);
    chk("restart_busy", 64'(busy_v[2]), 1);

    // saturation on the 9th sample of 2147352576
    do_start(3);
    for (int i = 0; i < 8; i++) begin
      send(3, 16'd32767, 16'd1);
      wait_ready_or_done(3);
    end
    chk("presat_sum", 64'(sum_v[3]), 64'd17178820608);
    chk("presat_sat", 64'(sat_v[3]), 0);
    send(3, 16'd32767, 16'd1);
    wait_done(3);
    chk("sat_sum", 64'(sum_v[3]), 64'd17179869183);
    chk("sat_flag", 64'(sat_v[3]), 1);

    // random runs against the ratio model
    for (int run = 0; run < 2; run++) begin
      do_start(4);
      msum = 0;
      mz = 0;
      for (int i = 0; i < 12; i++) begin
        r  = int'($urandom_range(0, 7));
        re = (r == 0) ? 16'd0 : (r == 1) ? 16'h8000 : 16'($urandom);
        ra = (r == 2) ? 16'h7fff : (r == 3) ? re : 16'($urandom);
        da = int'($signed(ra));
        de = int'($signed(re));
        d  = da - de;
        num = (d < 0) ? -d : d;
        den = (de < 0) ? -de : de;
        if (den == 0) begin
          mz++;
        end else begin
          q = (longint'(num) * 65536) / longint'(den);
          msum += q;
        end
        send(4, ra, re);
        wait_ready_or_done(4);
        chk("rand_sum", 64'(sum_v[4]), 64'(msum));
        chk("rand_scnt", 64'(scnt_v[4]), 64'(i + 1));
        chk("rand_zcnt", 64'(zcnt_v[4]), 64'(mz));
        $display("rand run=%0d i=%0d a=%0d e=%0d sum=%0d", run, i, da, de, sum_v[4]);
      end
      chk("rand_done", 64'(done_v[4]), 1);
    end

    // reset in the middle of a division
    do_start(0);
    send(0, 16'd300, 16'd7);
    tick(9);
    rstN = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready_v[0]), 0);
    chk("mid_rst_busy", 64'(busy_v[0]), 0);
    chk("mid_rst_done", 64'(done_v[0]), 0);
    chk("mid_rst_sum", 64'(sum_v[0]), 0);
    chk("mid_rst_scnt", 64'(scnt_v[0]), 0);
    chk("mid_rst_sat3", 64'(sat_v[3]), 0);
    @(negedge clk);
    rstN = 1'b1;
    valid_v[0] = 1'b1;
    tick(5);
    chk("post_rst_ready", 64'(ready_v[0]), 0);
    chk("post_rst_busy", 64'(busy_v[0]), 0);
    chk("post_rst_scnt", 64'(scnt_v[0]), 0);
    valid_v[0] = 1'b0;
    do_start(0);
    send(0, 16'd300, 16'd7);
    wait_done(0);
    chk("post_rst_sum", 64'(sum_v[0]), 2743149);
    chk("post_rst_cnt", 64'(scnt_v[0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
